// File: rtl/unary_pkg.sv
// Shared definitions for the unary adder datapath: decoder state encoding,
// the clog2-based width helper and the default unary length.
package unary_pkg;

    localparam int unsigned MAX_LEN_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        TAIL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bits needed to hold values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/unary_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear with inc loads 1.
module unary_sat_counter #(
    parameter int unsigned MAX = 16,
    parameter int unsigned W   = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] MAX_W = W'(MAX);

    assign sat = (cnt == MAX_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            if (clear) begin
                cnt <= W'(inc);
            end else if (inc && !sat) begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/unary_stream_decoder.sv
// Decodes a serial unary (thermometer) stream into a binary count with a valid pulse.
// Optional thermometer-form checking: define UNARY_STREAM_DECODER_ERR_CHECK_EN.
module unary_stream_decoder
    import unary_pkg::*;
#(
    parameter int unsigned MAX_LEN  = MAX_LEN_DEFAULT,
    parameter int unsigned CNT_W    = cnt_width(MAX_LEN),
    parameter int unsigned TAIL_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             frame,
    input  logic             din,
    input  logic             carry_in,
    output logic [CNT_W-1:0] count,
    output logic             carry_out,
    output logic             ovf,
    output logic             err,
    output logic             valid,
    output logic             busy
);

    localparam int unsigned   ZW     = cnt_width(TAIL_LEN);
    localparam logic [ZW-1:0] TAIL_Z = ZW'(TAIL_LEN);

    state_t           state;
    logic [CNT_W-1:0] acc;
    logic             sat;
    logic [ZW-1:0]    zrun;
    logic             carry_acc;
    logic             ovf_acc;
    logic             frame_seen;
    logic             start;
    logic             acc_inc;
    logic             carry_nxt;

    // A frame arms only from IDLE after frame has been seen low.
    assign start     = (state == IDLE) && frame && !frame_seen;
    assign acc_inc   = start ? din : ((state == COUNT) && frame && din);
    assign carry_nxt = carry_acc | (frame & carry_in);

    unary_sat_counter #(
        .MAX (MAX_LEN),
        .W   (CNT_W)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clear (start),
        .inc   (acc_inc),
        .cnt   (acc),
        .sat   (sat)
    );

`ifdef UNARY_STREAM_DECODER_ERR_CHECK_EN
    logic err_acc;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            zrun       <= '0;
            carry_acc  <= 1'b0;
            ovf_acc    <= 1'b0;
            frame_seen <= 1'b0;
            count      <= '0;
            carry_out  <= 1'b0;
            ovf        <= 1'b0;
            valid      <= 1'b0;
            busy       <= 1'b0;
`ifdef UNARY_STREAM_DECODER_ERR_CHECK_EN
            err_acc    <= 1'b0;
            err        <= 1'b0;
`endif
        end else if (en) begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!frame) begin
                        frame_seen <= 1'b0;
                    end else if (!frame_seen) begin
                        frame_seen <= 1'b1;
                        zrun       <= ZW'(!din);
                        carry_acc  <= carry_in;
                        ovf_acc    <= 1'b0;
                        busy       <= 1'b1;
                        state      <= din ? COUNT : TAIL;
`ifdef UNARY_STREAM_DECODER_ERR_CHECK_EN
                        err_acc    <= 1'b0;
`endif
                    end
                end
                COUNT, TAIL: begin
                    // Results are published on entry to DONE so valid is visible during DONE.
                    if (!frame || (state == TAIL && !din && (ZW'(zrun + 1'b1) == TAIL_Z))) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        valid     <= 1'b1;
                        count     <= acc;
                        carry_out <= carry_nxt;
                        ovf       <= ovf_acc;
`ifdef UNARY_STREAM_DECODER_ERR_CHECK_EN
                        err       <= err_acc;
`endif
                    end else begin
                        carry_acc <= carry_nxt;
                        if (state == COUNT) begin
                            if (din) begin
                                if (sat) ovf_acc <= 1'b1;
                            end else begin
                                zrun  <= ZW'(1);
                                state <= TAIL;
                            end
                        end else if (!din) begin
                            zrun <= ZW'(zrun + 1'b1);
                        end else begin
`ifdef UNARY_STREAM_DECODER_ERR_CHECK_EN
                            err_acc <= 1'b1;
                            zrun    <= '0;
`endif
                        end
                    end
                end
                DONE: begin
                    frame_seen <= frame;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Scoreboard bench for unary_stream_decoder: directed frames push expected
// results; a negedge monitor pops and compares on every valid pulse.
module tb_unary_stream_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       frame;
    logic       din;
    logic       carry_in;
    logic [4:0] count;
    logic       carry_out;
    logic       ovf;
    logic       err;
    logic       valid;
    logic       busy;

    unary_stream_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .frame     (frame),
        .din       (din),
        .carry_in  (carry_in),
        .count     (count),
        .carry_out (carry_out),
        .ovf       (ovf),
        .err       (err),
        .valid     (valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0] count;
        logic       carry;
        logic       ovf;
        logic       err;
        int         at;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

`ifdef UNARY_STREAM_DECODER_ERR_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [4:0] c, input logic cy, input logic o, input logic e, input int at);
        exp_t x;
        x.count = c;
        x.carry = cy;
        x.ovf   = o;
        x.err   = e;
        x.at    = at;
        q.push_back(x);
    endtask

    task automatic step(input logic f, input logic d, input logic c);
        frame    = f;
        din      = d;
        carry_in = c;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid pulse must match the oldest expected result.
    exp_t e;
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (q.size() == 0) begin
                check("spurious_valid", 32'(valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("count", 32'(count), 32'(e.count));
                check("carry_out", 32'(carry_out), 32'(e.carry));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("err", 32'(err), 32'(e.err));
                if (e.at >= 0) check("latency", 32'(cyc), 32'(e.at));
            end
        end
    end

    logic [8:0] pat;

    initial begin
        rst = 1'b1; en = 1'b1; frame = 1'b0; din = 1'b0; carry_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_count", 32'(count), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step(0, 0, 0);

        // Reset mid-frame: partial frame dropped, no valid.
        repeat (5) step(1, 1, 0);
        check("busy_mid_frame", 32'(busy), 32'd1);
        rst = 1'b1;
        repeat (3) step(0, 1, 1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_outs", 32'({count, carry_out, ovf, err, valid}), 32'd0);
        rst = 1'b0;
        repeat (3) step(0, 0, 0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // 12 ones then 4 zeros.
        repeat (12) step(1, 1, 0);
        repeat (3) step(1, 0, 0);
        push(5'd12, 1'b0, 1'b0, 1'b0, cyc + 1);
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);

        // 20 ones saturate at 16, carry seen once, frame falls.
        for (int i = 0; i < 20; i++) step(1, 1, logic'(i == 5));
        push(5'd16, 1'b1, 1'b1, 1'b0, cyc + 1);
        step(0, 0, 0);
        repeat (3) step(0, 0, 0);

        // Thermometer violation.
        pat = 9'b111010000;
        push(5'd3, 1'b0, 1'b0, ERR_EXP, -1);
        for (int i = 8; i >= 0; i--) step(1, pat[i], 0);
        repeat (3) step(0, 0, 0);

        // Enable low for 5 cycles mid-stream of 7 ones.
        repeat (3) step(1, 1, 0);
        en = 1'b0;
        repeat (5) step(1, 1, 0);
        check("busy_frozen", 32'(busy), 32'd1);
        en = 1'b1;
        repeat (4) step(1, 1, 0);
        repeat (3) step(1, 0, 0);
        push(5'd7, 1'b0, 1'b0, 1'b0, cyc + 1);
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);

        // Frame held high after DONE, then a fresh 2-one frame.
        repeat (3) step(1, 1, 0);
        repeat (3) step(1, 0, 0);
        push(5'd3, 1'b0, 1'b0, 1'b0, cyc + 1);
        step(1, 0, 0);
        repeat (4) step(1, 1, 0);
        check("held_frame_idle", 32'(busy), 32'd0);
        repeat (2) step(0, 0, 0);
        repeat (2) step(1, 1, 0);
        push(5'd2, 1'b0, 1'b0, 1'b0, cyc + 1);
        step(0, 0, 0);
        repeat (3) step(0, 0, 0);

        // Empty frame: four zeros.
        repeat (3) step(1, 0, 0);
        push(5'd0, 1'b0, 1'b0, 1'b0, cyc + 1);
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);

        // Frame high for exactly one cycle.
        step(1, 1, 0);
        push(5'd1, 1'b0, 1'b0, 1'b0, cyc + 1);
        step(0, 0, 0);
        repeat (3) step(0, 0, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) step(0, 0, 0);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
